// File: rtl/instr_fetch.sv
// Fetch stage in front of the main control decoder: holds the PC, issues word
// requests to instruction memory, captures the returned word into IR and
// presents its opcode. Handles beq redirect, downstream stall and halts on an
// opcode the decoder does not support.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] IR,
    output logic [5:0]  OpCode,
    output logic [31:0] PCplus4,
    output logic        if_valid,
    output logic        if_illegal
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        capture;
    logic        branch;
    logic        consume;
    logic        illegal;

    // Sequential address; wraps modulo 2^32.
    function automatic logic [31:0] pc_add(input logic [31:0] a);
        return a + PC_INC;
    endfunction

    // Opcodes the decoder understands: R-type, beq, lw, sw.
    function automatic logic is_legal(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'd4) || (op == 6'd35) || (op == 6'd43);
    endfunction

    assign pc_next   = pc_add(pc);
    assign imem_addr = pc;
    assign OpCode    = IR[31:26];

    // Next-state, request and event decode; branch wins over capture.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        capture    = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        consume    = if_valid & ~id_stall;
        case (state)
            BOOT: begin
                state_next = FETCH;
                branch     = br_taken;
            end
            FETCH: begin
                imem_req = ~(if_valid & id_stall);
                branch   = br_taken;
                capture  = imem_req & imem_ready & ~br_taken;
                illegal  = capture & ~is_legal(imem_rdata[31:26]);
                if (illegal) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // PC, IF/ID register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            IR         <= '0;
            PCplus4    <= '0;
            if_valid   <= 1'b0;
            if_illegal <= 1'b0;
        end else if (branch) begin
            pc       <= br_target;
            if_valid <= 1'b0;
        end else if (capture) begin
            IR       <= imem_rdata;
            PCplus4  <= pc_next;
            if_valid <= 1'b1;
            if (illegal) begin
                if_illegal <= 1'b1;
            end else begin
                pc <= pc_next;
            end
        end else if (consume) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus pushes expected captures into a
// scoreboard queue, a monitor pops and compares on every memory handshake.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] IR;
    logic [5:0]  OpCode;
    logic [31:0] PCplus4;
    logic        if_valid;
    logic        if_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] pc4;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    instr_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .br_taken(br_taken), .br_target(br_target),
        .IR(IR), .OpCode(OpCode), .PCplus4(PCplus4),
        .if_valid(if_valid), .if_illegal(if_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] w, input logic [31:0] p4, input logic il);
        exp_t e;
        e.addr = a; e.word = w; e.pc4 = p4; e.ill = il;
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs just after the falling edge.
    task automatic step(input logic rdy, input logic [31:0] data, input logic stl,
                        input logic br, input logic [31:0] tgt);
        @(negedge clk);
        imem_ready = rdy; imem_rdata = data; id_stall = stl;
        br_taken = br; br_target = tgt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; id_stall = 1'b0;
        br_taken = 1'b0; br_target = '0;
        #1 chk("rst_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Monitor: on each handshake, compare the captured word after the edge.
    always @(negedge clk) begin
        logic        hs;
        logic [31:0] a;
        exp_t        e;
        #4;
        hs = !rst && imem_req && imem_ready && !br_taken;
        a  = imem_addr;
        if (hs) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", a, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", a, e.addr);
                chk("sb_ir", IR, e.word);
                chk("sb_opcode", {26'b0, OpCode}, {26'b0, e.word[31:26]});
                chk("sb_pc4", PCplus4, e.pc4);
                chk("sb_valid", {31'b0, if_valid}, 32'd1);
                chk("sb_illegal", {31'b0, if_illegal}, {31'b0, e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and zero-wait sequential fetch.
        do_reset();
        chk("rst_ir", IR, 32'd0);
        chk("rst_pc4", PCplus4, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_illegal", {31'b0, if_illegal}, 32'd0);
        chk("boot_req", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'd0);
            push(i * 4, 32'h0000_0020, i * 4 + 4, 1'b0);
            chk("seq_req", {31'b0, imem_req}, 32'd1);
            chk("seq_addr", imem_addr, i * 4);
        end
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("seq_end_addr", imem_addr, 32'd16);

        // Stall with lw held, then two wait states at PC=8.
        do_reset();
        step(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'd0);
        push(32'd0, 32'h0000_0020, 32'd4, 1'b0);
        step(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 32'd0);
        push(32'd4, 32'h8C01_0004, 32'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_ir", IR, 32'h8C01_0004);
            chk("stall_pc4", PCplus4, 32'd8);
            chk("stall_addr", imem_addr, 32'd8);
            chk("stall_valid", {31'b0, if_valid}, 32'd1);
        end
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("wait1_req", {31'b0, imem_req}, 32'd1);
        chk("wait1_addr", imem_addr, 32'd8);
        chk("wait1_ir", IR, 32'h8C01_0004);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("wait2_req", {31'b0, imem_req}, 32'd1);
        chk("wait2_addr", imem_addr, 32'd8);
        chk("wait2_valid", {31'b0, if_valid}, 32'd0);
        step(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'd0);
        push(32'd8, 32'h0000_0020, 32'd12, 1'b0);

        // Branch drops the word returned in the same cycle.
        step(1'b1, 32'hAC00_0000, 1'b0, 1'b1, 32'h0000_0040);
        chk("br1_addr", imem_addr, 32'd12);
        step(1'b1, 32'h1000_0000, 1'b0, 1'b0, 32'd0);
        chk("br1_valid", {31'b0, if_valid}, 32'd0);
        chk("br1_illegal", {31'b0, if_illegal}, 32'd0);
        chk("br1_target", imem_addr, 32'h0000_0040);
        chk("br1_req", {31'b0, imem_req}, 32'd1);
        push(32'h40, 32'h1000_0000, 32'h44, 1'b0);
        step(1'b1, 32'h2000_0001, 1'b0, 1'b1, 32'h0000_0010);
        chk("br2_addr", imem_addr, 32'h44);
        step(1'b1, 32'h2000_0001, 1'b1, 1'b0, 32'd0);
        chk("br2_valid", {31'b0, if_valid}, 32'd0);
        chk("br2_illegal", {31'b0, if_illegal}, 32'd0);
        chk("br2_target", imem_addr, 32'h10);
        push(32'h10, 32'h2000_0001, 32'h14, 1'b1);

        // Halted: no requests, branch ignored, IR held under stall.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0080);
            chk("halt_req", {31'b0, imem_req}, 32'd0);
            chk("halt_addr", imem_addr, 32'h10);
            chk("halt_valid", {31'b0, if_valid}, 32'd1);
            chk("halt_illegal", {31'b0, if_illegal}, 32'd1);
            chk("halt_ir", IR, 32'h2000_0001);
        end
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("halt_br_ignored", imem_addr, 32'h10);
        chk("halt_req2", {31'b0, imem_req}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("halt_consumed", {31'b0, if_valid}, 32'd0);
        chk("halt_sticky", {31'b0, if_illegal}, 32'd1);
        do_reset();
        chk("rearm_illegal", {31'b0, if_illegal}, 32'd0);
        chk("rearm_addr", imem_addr, 32'd0);

        // Branch taken in BOOT to the top word, then wrap.
        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        step(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'd0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req", {31'b0, imem_req}, 32'd1);
        push(32'hFFFF_FFFC, 32'h0000_0020, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("wrap_pc", imem_addr, 32'd0);
        chk("wrap_pc4", PCplus4, 32'd0);

        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
